// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed seven-segment display.
// Walks the digits through BLANK/SHOW slots and swaps in new contents only at frame wrap.
module seg_scan_ctrl #(
    parameter int SHOW_CYC  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic        lz_blank,
    output logic [2:0]  sel,
    output logic        dig_en,
    output logic [3:0]  bcd,
    output logic        pending,
    output logic        frame_done
);

    localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} scanState_t;

    scanState_t       state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [2:0]       selNext;
    logic [31:0]      disp, dispNext;
    logic [31:0]      pendBuf, pendBufNext;
    logic             pendingNext;
    logic             wrap;
    logic             commit;

    // Digit k stays dark only when blanking is on and it and every digit to its left are zero.
    function automatic logic digitLit(input logic [31:0] digits, input logic [2:0] k,
                                      input logic lzBlank);
        logic [31:0] upper;
        upper = digits >> {k, 2'b00};
        return (k == 3'd0) || !lzBlank || (upper != 32'd0);
    endfunction

    always_comb begin
        stateNext = state;
        selNext   = sel;
        cntNext   = cnt;
        wrap      = 1'b0;
        if (!en) begin
            stateNext = IDLE;
            selNext   = 3'd0;
            cntNext   = '0;
        end else begin
            case (state)
                IDLE: begin
                    stateNext = BLANK;
                    selNext   = 3'd0;
                    cntNext   = '0;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cntNext   = '0;
                        stateNext = SHOW;
                    end else begin
                        cntNext = cnt + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cntNext   = '0;
                        selNext   = sel + 3'd1;
                        stateNext = BLANK;
                        wrap      = (sel == 3'd7);
                    end else begin
                        cntNext = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    stateNext = IDLE;
                    selNext   = 3'd0;
                    cntNext   = '0;
                end
            endcase
        end

        // A load on the commit edge still goes to pendBuf, so pending must stay set.
        commit      = pending && (wrap || state == IDLE);
        dispNext    = commit ? pendBuf : disp;
        pendBufNext = load ? data_in : pendBuf;
        pendingNext = load ? 1'b1 : (commit ? 1'b0 : pending);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 3'd0;
            cnt        <= '0;
            disp       <= 32'd0;
            pendBuf    <= 32'd0;
            pending    <= 1'b0;
            dig_en     <= 1'b0;
            bcd        <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            state      <= stateNext;
            sel        <= selNext;
            cnt        <= cntNext;
            disp       <= dispNext;
            pendBuf    <= pendBufNext;
            pending    <= pendingNext;
            dig_en     <= (stateNext == SHOW) && digitLit(dispNext, selNext, lz_blank);
            bcd        <= dispNext[{selNext, 2'b00} +: 4];
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with short slots (SHOW_CYC=4, BLANK_CYC=2).
module tb_seg_scan_ctrl;

    localparam int SHOW  = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = SHOW + BLANK;
    localparam int FRAME = 8 * SLOT;

    localparam logic [31:0] VAL_A = 32'h2468_1357;
    localparam logic [31:0] VAL_B = 32'h9081_7263;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [31:0] data_in;
    logic        lz_blank;
    logic [2:0]  sel;
    logic        dig_en;
    logic [3:0]  bcd;
    logic        pending;
    logic        frame_done;

    int          nChecks = 0;
    int          nFails  = 0;
    int          p;
    logic [31:0] expDisp;
    logic [7:0]  litMask;
    logic        expPend;

    seg_scan_ctrl #(.SHOW_CYC(SHOW), .BLANK_CYC(BLANK)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in),
        .lz_blank(lz_blank), .sel(sel), .dig_en(dig_en), .bcd(bcd),
        .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h (p=%0d, t=%0t)", tag, obs, exp, p, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Position p counts edges since the scan entered BLANK of digit 0.
    task automatic checkScan();
        int         slot;
        int         w;
        logic [2:0] s;
        slot = p / SLOT;
        w    = p % SLOT;
        s    = 3'(slot % 8);
        checkVal("sel", 32'(sel), 32'(s));
        checkVal("dig_en", 32'(dig_en), 32'((w >= BLANK) && litMask[s]));
        checkVal("bcd", 32'(bcd), 32'(expDisp[4*s +: 4]));
        checkVal("frame_done", 32'(frame_done), 32'((p % FRAME == 0) && (p > 0)));
        checkVal("pending", 32'(pending), 32'(expPend));
    endtask

    task automatic scanRun(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            p = i;
            checkScan();
            tick();
        end
    endtask

    task automatic loadIdle(input logic [31:0] v);
        load    = 1'b1;
        data_in = v;
        tick();
        load = 1'b0;
        checkVal("idle_pending_set", 32'(pending), 32'd1);
        tick();
        checkVal("idle_pending_clr", 32'(pending), 32'd0);
        checkVal("idle_bcd", 32'(bcd), 32'(v[3:0]));
        checkVal("idle_dig_en", 32'(dig_en), 32'd0);
    endtask

    task automatic startScan();
        en = 1'b1;
        tick();
        p = 0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        data_in  = 32'd0;
        lz_blank = 1'b0;
        p        = 0;
        expDisp  = 32'd0;
        litMask  = 8'hFF;
        expPend  = 1'b0;

        #12;
        checkVal("rst_sel", 32'(sel), 32'd0);
        checkVal("rst_dig_en", 32'(dig_en), 32'd0);
        checkVal("rst_bcd", 32'(bcd), 32'd0);
        checkVal("rst_pending", 32'(pending), 32'd0);
        checkVal("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkVal("idle_after_rst", 32'(dig_en), 32'd0);

        // Scan order, frame-aligned commit and load collision over five frames
        loadIdle(32'h8765_4321);
        startScan();
        for (int i = 0; i < 255; i++) begin
            p = i;
            case (i / FRAME)
                0, 1:    expDisp = 32'h8765_4321;
                2:       expDisp = 32'h1111_1111;
                3:       expDisp = VAL_A;
                default: expDisp = VAL_B;
            endcase
            expPend = (i >= 67 && i < 96) || (i >= 133 && i < 192);
            checkScan();
            load = (i == 66) || (i == 132) || (i == 143);
            if (i == 66)       data_in = 32'h1111_1111;
            else if (i == 132) data_in = VAL_A;
            else if (i == 143) data_in = VAL_B;
            if (i == 254) en = 1'b0;
            tick();
        end
        load = 1'b0;

        // en dropped during SHOW of digit 2
        checkVal("drop_dig_en", 32'(dig_en), 32'd0);
        checkVal("drop_sel", 32'(sel), 32'd0);
        checkVal("drop_bcd", 32'(bcd), 32'(VAL_B[3:0]));
        checkVal("drop_frame_done", 32'(frame_done), 32'd0);
        tick();
        tick();
        checkVal("drop_idle_dig_en", 32'(dig_en), 32'd0);

        expDisp = VAL_B;
        expPend = 1'b0;
        startScan();
        scanRun(0, 11);

        // Leading-zero blanking
        en = 1'b0;
        tick();
        loadIdle(32'd0);
        lz_blank = 1'b1;
        expDisp  = 32'd0;
        litMask  = 8'h01;
        startScan();
        scanRun(0, FRAME);

        en = 1'b0;
        tick();
        loadIdle(32'h0000_0340);
        expDisp = 32'h0000_0340;
        litMask = 8'h07;
        startScan();
        scanRun(0, FRAME);

        en = 1'b0;
        tick();
        lz_blank = 1'b0;
        litMask  = 8'hFF;
        startScan();
        scanRun(0, FRAME);

        // Asynchronous reset in the middle of SHOW for digit 5
        en = 1'b0;
        tick();
        loadIdle(32'h8765_4321);
        expDisp = 32'h8765_4321;
        expPend = 1'b0;
        startScan();
        p = 0;
        checkScan();
        load    = 1'b1;
        data_in = 32'h5555_5555;
        tick();
        load    = 1'b0;
        expPend = 1'b1;
        scanRun(1, 32);
        p = 33;
        checkScan();
        #2;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        checkVal("arst_sel", 32'(sel), 32'd0);
        checkVal("arst_dig_en", 32'(dig_en), 32'd0);
        checkVal("arst_bcd", 32'(bcd), 32'd0);
        checkVal("arst_pending", 32'(pending), 32'd0);
        checkVal("arst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            checkVal("idle_frame_done", 32'(frame_done), 32'd0);
            checkVal("idle_dig_en", 32'(dig_en), 32'd0);
            checkVal("idle_sel", 32'(sel), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for an 8-digit common-anode seven-segment display. It owns the shared 3-8 digit-select decoder and the single BCD-to-seven-segment decoder, and steps through the digits one at a time. For each digit it drives the select code, the decoder enable and the BCD nibble for that digit. New display contents are double-buffered and committed only at frame boundaries, so a displayed frame never mixes old and new digits.

## Interface
- SHOW_CYC, 1000: clock cycles each digit is lit per slot; must be ≥1.
- BLANK_CYC, 16: dead cycles before each digit (all digits off, ghosting guard); must be ≥1.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; low forces IDLE.
- load  in  1  single-cycle strobe; capture data_in into pending buffer.
- data_in  in  32  eight BCD digits; digit k = data_in[4k+3:4k], digit 0 rightmost.
- lz_blank  in  1  leading-zero suppression enable.
- sel  out  3  digit index, drives 3-8 decoder A[2:0].
- dig_en  out  1  drives decoder S1 (notS2/notS3 tied low at top level); 1 lights digit sel.
- bcd  out  4  nibble of digit sel, drives BCD-to-seven decoder.
- pending  out  1  pending buffer holds uncommitted data.
- frame_done  out  1  one-cycle pulse on each 7→0 wrap.

## Operation
- Registers: pend_buf[31:0], disp[31:0], pending, state, sel, cnt (wide enough for max(SHOW_CYC, BLANK_CYC)−1).
- States: IDLE, BLANK, SHOW.
  - IDLE: dig_en=0, sel=0, cnt=0. When en=1, go to BLANK next cycle.
  - BLANK: dig_en=0. cnt runs 0..BLANK_CYC−1, then cnt=0 → SHOW.
  - SHOW: dig_en=lit(sel). cnt runs 0..SHOW_CYC−1, then cnt=0, sel=sel+1 (mod 8) → BLANK.
- en=0 in any state → IDLE on the next edge. sel and cnt clear; disp is retained.
- bcd = disp[4·sel+3:4·sel] in every state. Values 10-15 pass through unchanged; glyph choice belongs to the decoder.
- lit(k):
  - k=0: always 1.
  - k≥1: 0 when lz_blank=1 and digits k..7 of disp are all zero; otherwise 1.
- Loading:
  - load=1: pend_buf←data_in, pending←1. A second load before commit overwrites pend_buf (last write wins).
- Commit (disp←pend_buf, pending←0), only when pending=1:
  - on the SHOW→BLANK edge where sel goes 7→0; or
  - on any edge while in IDLE.
- Load and commit on the same edge: disp takes the old pend_buf, pend_buf takes data_in, pending stays 1.
- frame_done=1 for exactly the cycle following the 7→0 wrap edge. It fires whether or not a commit occurs.

## Timing
- All outputs are registered. Reset values: sel=0, dig_en=0, bcd=0, pending=0, frame_done=0, disp=0, pend_buf=0, state=IDLE.
- Slot length = BLANK_CYC+SHOW_CYC cycles; frame = 8 slots.
- en sampled high at edge E0:
  - edge E0: IDLE→BLANK.
  - dig_en first rises on edge E0+BLANK_CYC (digit 0).
- dig_en never goes high in the same cycle sel changes: every sel change happens on an edge into BLANK.
- Reset asserted mid-frame: all outputs go to reset values immediately, without waiting for clk. After deassertion the block stays in IDLE until en is sampled high.
- load in IDLE with no scanning: disp updates on the following edge; pending reads 1 for exactly one cycle.

## Test plan
- Reset/idle:
  - Stimulus: assert rst mid-SHOW of digit 5.
  - Response: sel=0, dig_en=0, bcd=0, pending=0 asynchronously; no frame_done while en=0.
- Scan order (SHOW_CYC=4, BLANK_CYC=2, en=1, disp=0x87654321):
  - sel steps 0..7 then back to 0, with dig_en low 2 cycles and high 4 cycles per slot.
  - bcd = 1,2,…,8 per slot.
  - frame_done pulses once every 48 cycles.
- Frame-aligned commit:
  - Stimulus: load 0x11111111 while sel=3.
  - Response: bcd of digits 4..7 still shows old values; pending=1 until the 7→0 edge; the next frame shows all 1s.
- Leading-zero blanking:
  - disp=0x00000340, lz_blank=1: dig_en stays 0 in SHOW for sel 3..7, is 1 for sel 0..2.
  - disp=0, lz_blank=1: only digit 0 lit.
  - lz_blank=0: all 8 digits lit.
- Load collision:
  - Stimulus: load A at sel=6, then load B on the wrap edge itself.
  - Response: next frame displays A; pending=1; frame after that displays B.
- en drop:
  - Stimulus: en=0 mid-SHOW of digit 2.
  - Response: dig_en=0 and sel=0 next cycle.
  - Re-enable: first lit cycle is digit 0, BLANK_CYC cycles after en is sampled high.
